// File: rtl/fifo_wr_packer_pkg.sv
// Shared types and defaults for the byte-to-word FIFO write packer.
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        ST_EVEN  = 2'd0,
        ST_ODD   = 2'd1,
        ST_TRAIL = 2'd2
    } state_t;

    localparam int          MARGIN_DEFAULT = 4;
    localparam logic [7:0]  PAD_DEFAULT    = 8'h00;
    localparam int          TRAILER_W      = 16;

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs a framed byte stream into 16-bit FIFO words, appends a byte-count
// trailer per frame, and throttles the source on FIFO almost-full.
module fifo_wr_packer
    import fifo_wr_pkg::*;
#(
    parameter int         SHENBIT = 11,
    parameter int         MARGIN  = MARGIN_DEFAULT,
    parameter logic [7:0] PAD     = PAD_DEFAULT
) (
    input  logic               wrclk,
    input  logic               aclr,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    input  logic [SHENBIT-1:0] wrusedw,
    input  logic               wrfull,
    output logic               wrreq,
    output logic [15:0]        data,
    output logic [15:0]        frame_cnt,
    output logic               ovf_err,
    input  logic               clr_err
);

    localparam logic [SHENBIT:0] AF_LEVEL = (SHENBIT + 1)'((1 << SHENBIT) - MARGIN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_hold;
    logic [TRAILER_W-1:0]   r_byte_cnt;
    logic                   r_wrreq;
    logic [15:0]            r_data;
    logic [15:0]            r_frame_cnt;
    logic                   r_ovf_err;

    logic                   w_almost_full;
    logic                   w_accept;
    logic                   w_emit;
    logic                   w_trailer;
    logic [15:0]            w_word;

    assign w_almost_full = wrfull || ({1'b0, wrusedw} >= AF_LEVEL);
    // Gated by aclr so the source sees no ready while the block is held in reset.
    assign s_ready       = aclr && !w_almost_full && (r_state != ST_TRAIL);
    assign w_accept      = s_valid && s_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wrclk or negedge aclr) begin
        if (!aclr) r_state <= ST_EVEN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_EVEN:  if (w_accept) w_state_nxt = s_last ? ST_TRAIL : ST_ODD;
            ST_ODD:   if (w_accept) w_state_nxt = s_last ? ST_TRAIL : ST_EVEN;
            ST_TRAIL: if (!w_almost_full) w_state_nxt = ST_EVEN;
            default:  w_state_nxt = ST_EVEN;
        endcase
    end

    always_comb begin
        w_emit    = 1'b0;
        w_trailer = 1'b0;
        w_word    = r_data;
        case (r_state)
            ST_EVEN: if (w_accept && s_last) begin
                w_emit = 1'b1;
                w_word = {s_data, PAD};
            end
            ST_ODD: if (w_accept) begin
                w_emit = 1'b1;
                w_word = {r_hold, s_data};
            end
            ST_TRAIL: if (!w_almost_full) begin
                w_emit    = 1'b1;
                w_trailer = 1'b1;
                w_word    = r_byte_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wrclk or negedge aclr) begin
        if (!aclr) begin
            r_hold      <= '0;
            r_byte_cnt  <= '0;
            r_wrreq     <= 1'b0;
            r_data      <= '0;
            r_frame_cnt <= '0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_wrreq <= w_emit;
            if (w_emit) r_data <= w_word;
            if (w_accept && (r_state == ST_EVEN) && !s_last) r_hold <= s_data;
            if (w_trailer) begin
                r_byte_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (w_accept) begin
                r_byte_cnt  <= r_byte_cnt + 1'b1;
            end
            // Overflow is judged on the word currently presented to the FIFO; set beats clear.
            if (r_wrreq && wrfull) r_ovf_err <= 1'b1;
            else if (clr_err)      r_ovf_err <= 1'b0;
        end
    end

    assign wrreq     = r_wrreq;
    assign data      = r_data;
    assign frame_cnt = r_frame_cnt;
    assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench: frame-level reference model plus directed literal cases.
module tb_fifo_wr_packer;

    localparam int          SHENBIT  = 11;
    localparam int          MARGIN   = 4;
    localparam logic [7:0]  PAD      = 8'h00;
    localparam int          AF_LEVEL = (1 << SHENBIT) - MARGIN;

    logic               wrclk = 1'b0;
    logic               aclr = 1'b0;
    logic [7:0]         s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_last = 1'b0;
    logic               s_ready;
    logic [SHENBIT-1:0] wrusedw = '0;
    logic               wrfull = 1'b0;
    logic               wrreq;
    logic [15:0]        data;
    logic [15:0]        frame_cnt;
    logic               ovf_err;
    logic               clr_err = 1'b0;

    int checks = 0;
    int failures = 0;

    fifo_wr_packer dut (
        .wrclk(wrclk), .aclr(aclr),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .wrusedw(wrusedw), .wrfull(wrfull),
        .wrreq(wrreq), .data(data), .frame_cnt(frame_cnt),
        .ovf_err(ovf_err), .clr_err(clr_err)
    );

    initial forever #5 wrclk = ~wrclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: bytes of the open frame, and expected registered outputs.
    logic [7:0]  frame_bytes[$];
    bit          trail_pending = 1'b0;
    logic        exp_wrreq = 1'b0;
    logic [15:0] exp_data = '0;
    logic [15:0] exp_fc = '0;
    logic        exp_ovf = 1'b0;
    logic [15:0] cap[$];

    initial begin
        bit af, rdy, nxt_wr, nxt_ovf;
        int n;
        forever begin
            @(negedge wrclk);
            #4;
            if (!aclr) begin
                check("s_ready_in_reset", s_ready, 1'b0);
                frame_bytes.delete();
                trail_pending = 1'b0;
                exp_wrreq = 1'b0;
                exp_data  = '0;
                exp_fc    = '0;
                exp_ovf   = 1'b0;
            end else begin
                af  = wrfull || (int'(wrusedw) >= AF_LEVEL);
                rdy = !af && !trail_pending;
                check("s_ready", s_ready, rdy);
                nxt_ovf = (exp_wrreq && wrfull) ? 1'b1 : (clr_err ? 1'b0 : exp_ovf);
                nxt_wr  = 1'b0;
                if (trail_pending) begin
                    if (!af) begin
                        nxt_wr   = 1'b1;
                        exp_data = 16'(frame_bytes.size());
                        frame_bytes.delete();
                        trail_pending = 1'b0;
                        exp_fc++;
                    end
                end else if (s_valid && rdy) begin
                    frame_bytes.push_back(s_data);
                    n = frame_bytes.size();
                    if (n % 2 == 0) begin
                        nxt_wr   = 1'b1;
                        exp_data = {frame_bytes[n-2], frame_bytes[n-1]};
                    end else if (s_last) begin
                        nxt_wr   = 1'b1;
                        exp_data = {s_data, PAD};
                    end
                    if (s_last) trail_pending = 1'b1;
                end
                exp_wrreq = nxt_wr;
                exp_ovf   = nxt_ovf;
            end
            @(posedge wrclk);
            #1;
            check("wrreq", wrreq, exp_wrreq);
            check("data", data, exp_data);
            check("frame_cnt", frame_cnt, exp_fc);
            check("ovf_err", ovf_err, exp_ovf);
            if (wrreq) cap.push_back(data);
        end
    end

    // Random FIFO-side environment, active only during the random phase.
    bit rand_env = 1'b0;
    initial forever begin
        @(negedge wrclk);
        if (rand_env) begin
            if ($urandom_range(0, 99) < 15)
                wrusedw = SHENBIT'($urandom_range(AF_LEVEL - 2, (1 << SHENBIT) - 1));
            else
                wrusedw = SHENBIT'($urandom_range(0, 100));
            wrfull  = ($urandom_range(0, 99) < 3);
            clr_err = ($urandom_range(0, 99) < 5);
        end
    end

    task automatic do_reset();
        @(negedge wrclk);
        aclr = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        wrfull = 1'b0; wrusedw = '0; clr_err = 1'b0;
        repeat (3) @(negedge wrclk);
        #3;
        check("rst_wrreq", wrreq, 1'b0);
        check("rst_data", data, 16'h0000);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        check("rst_ovf_err", ovf_err, 1'b0);
        @(negedge wrclk);
        aclr = 1'b1;
        cap.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, output int stalls);
        @(negedge wrclk);
        s_data = b; s_last = last; s_valid = 1'b1;
        #3;
        stalls = 0;
        while (!s_ready && stalls < 300) begin
            stalls++;
            @(negedge wrclk);
            #3;
        end
        check("handshake_ready", s_ready, 1'b1);
    endtask

    task automatic send_frame(input int len, input bit bubbles, output int first_stall, output int rest_stall);
        int st;
        first_stall = 0;
        rest_stall  = 0;
        for (int i = 0; i < len; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(negedge wrclk);
                s_valid = 1'b0;
            end
            send_byte(8'($urandom), (i == len - 1), st);
            if (i == 0) first_stall = st;
            else        rest_stall += st;
        end
    endtask

    task automatic idle(input int cycles);
        @(negedge wrclk);
        s_valid = 1'b0;
        repeat (cycles) @(negedge wrclk);
    endtask

    initial begin
        int st, fs, rs;

        // Frame of four bytes: two data words and a count trailer.
        do_reset();
        send_byte(8'h11, 0, st); send_byte(8'h22, 0, st);
        send_byte(8'h33, 0, st); send_byte(8'h44, 1, st);
        idle(4);
        check("even_frame_words", cap.size(), 3);
        check("even_w0", cap[0], 16'h1122);
        check("even_w1", cap[1], 16'h3344);
        check("even_trailer", cap[2], 16'h0004);
        check("even_frame_cnt", frame_cnt, 16'd1);

        // Odd-length frame gets a padded final word.
        do_reset();
        send_byte(8'hA1, 0, st); send_byte(8'hB2, 0, st); send_byte(8'hC3, 1, st);
        idle(4);
        check("odd_frame_words", cap.size(), 3);
        check("odd_w0", cap[0], 16'hA1B2);
        check("odd_w1", cap[1], 16'hC300);
        check("odd_trailer", cap[2], 16'h0003);
        check("odd_frame_cnt", frame_cnt, 16'd1);

        // Trailer held back while the FIFO sits at the almost-full threshold.
        do_reset();
        send_byte(8'h11, 0, st); send_byte(8'h22, 0, st);
        send_byte(8'h33, 0, st); send_byte(8'h44, 1, st);
        @(negedge wrclk);
        s_valid = 1'b0;
        wrusedw = SHENBIT'(AF_LEVEL);
        for (int i = 0; i < 5; i++) begin
            #3;
            check("trail_blocked_ready", s_ready, 1'b0);
            @(negedge wrclk);
        end
        check("trail_blocked_words", cap.size(), 2);
        wrusedw = SHENBIT'(AF_LEVEL - 1);
        repeat (3) @(negedge wrclk);
        check("trail_release_words", cap.size(), 3);
        check("trail_release_word", cap[2], 16'h0004);
        check("trail_release_frame_cnt", frame_cnt, 16'd1);

        // Sticky overflow flag, clear, and set-beats-clear.
        do_reset();
        send_byte(8'h01, 0, st); send_byte(8'h02, 0, st);
        @(negedge wrclk);
        s_valid = 1'b0; wrfull = 1'b1;
        @(negedge wrclk);
        wrfull = 1'b0;
        #3;
        check("ovf_set", ovf_err, 1'b1);
        repeat (2) @(negedge wrclk);
        #3;
        check("ovf_sticky", ovf_err, 1'b1);
        @(negedge wrclk);
        clr_err = 1'b1;
        @(negedge wrclk);
        clr_err = 1'b0;
        #3;
        check("ovf_cleared", ovf_err, 1'b0);
        send_byte(8'h03, 0, st); send_byte(8'h04, 0, st);
        @(negedge wrclk);
        s_valid = 1'b0; wrfull = 1'b1; clr_err = 1'b1;
        @(negedge wrclk);
        wrfull = 1'b0; clr_err = 1'b0;
        #3;
        check("ovf_set_beats_clear", ovf_err, 1'b1);
        check("ovf_words", cap.size(), 2);

        // Reset mid-frame drops the held byte; the next frame starts clean.
        do_reset();
        send_byte(8'h55, 0, st);
        @(negedge wrclk);
        s_valid = 1'b0; aclr = 1'b0;
        repeat (2) @(negedge wrclk);
        aclr = 1'b1;
        check("midreset_no_words", cap.size(), 0);
        send_byte(8'h66, 0, st); send_byte(8'h77, 1, st);
        idle(4);
        check("midreset_words", cap.size(), 2);
        check("midreset_w0", cap[0], 16'h6677);
        check("midreset_trailer", cap[1], 16'h0002);
        check("midreset_frame_cnt", frame_cnt, 16'd1);

        // Back-to-back frames with s_valid held: exactly one stall per frame boundary.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_frame($urandom_range(1, 6), 1'b0, fs, rs);
            check("b2b_first_stall", fs, (f == 0) ? 0 : 1);
            check("b2b_rest_stall", rs, 0);
        end
        idle(4);
        check("b2b_frame_cnt", frame_cnt, 16'd3);

        // Randomized frames, bubbles and FIFO pressure against the model.
        do_reset();
        rand_env = 1'b1;
        for (int f = 0; f < 150; f++) begin
            send_frame($urandom_range(1, 9), 1'b1, fs, rs);
        end
        @(negedge wrclk);
        rand_env = 1'b0;
        s_valid = 1'b0; wrfull = 1'b0; wrusedw = '0; clr_err = 1'b0;
        repeat (6) @(negedge wrclk);
        check("random_frame_cnt", frame_cnt, 16'd150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter SHENBIT, default 11, FIFO address width (depth 2**SHENBIT words).
REQ-002 SHALL have parameter MARGIN, default 4, free-word headroom below which input is throttled.
REQ-003 SHALL have parameter PAD, default 8'h00, filler byte for odd-length frames.
REQ-004 SHALL have port wrclk  input  1  write-domain clock; all logic on rising edge.
REQ-005 SHALL have port aclr  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_data  input  8  byte from upstream source.
REQ-007 SHALL have port s_valid  input  1  s_data/s_last valid.
REQ-008 SHALL have port s_last  input  1  current byte ends the frame.
REQ-009 SHALL have port s_ready  output  1  byte accepted when s_valid and s_ready are both 1.
REQ-010 SHALL have port wrusedw  input  SHENBIT  FIFO write-side fill count.
REQ-011 SHALL have port wrfull  input  1  FIFO write-side full flag.
REQ-012 SHALL have port wrreq  output  1  FIFO write enable, one pulse per word.
REQ-013 SHALL have port data  output  16  FIFO write word.
REQ-014 SHALL have port frame_cnt  output  16  completed frames, wraps modulo 2^16.
REQ-015 SHALL have port ovf_err  output  1  sticky: a word was written while wrfull=1.
REQ-016 SHALL have port clr_err  input  1  synchronous clear of ovf_err.

Function
REQ-017 SHALL compute almost_full = wrfull OR (wrusedw >= 2**SHENBIT - MARGIN), combinationally from inputs.
REQ-018 SHALL drive s_ready = 1 only when state is EVEN or ODD and almost_full = 0.
REQ-019 SHALL implement FSM states EVEN (no held byte), ODD (high byte held), TRAIL (trailer pending).
REQ-020 EVEN + accepted byte, s_last=0: SHALL latch byte into hold register, go to ODD, no write.
REQ-021 EVEN + accepted byte, s_last=1: SHALL write {byte, PAD}, go to TRAIL.
REQ-022 ODD + accepted byte: SHALL write {hold, byte}; next state EVEN if s_last=0, TRAIL if s_last=1.
REQ-023 EVEN/ODD with no accepted byte: SHALL hold state and register contents, wrreq=0.
REQ-024 TRAIL with almost_full=0: SHALL write trailer word = frame byte count [15:0], increment frame_cnt, clear byte count, go to EVEN.
REQ-025 TRAIL with almost_full=1: SHALL stay in TRAIL, wrreq=0.
REQ-026 Byte order: first byte of each pair SHALL occupy data[15:8].
REQ-027 Byte count SHALL increment per accepted byte of current frame (including last byte), wrapping modulo 2^16; PAD byte not counted.
REQ-028 wrreq and data SHALL be registered: word appears the cycle after the accepting edge; wrreq high exactly one cycle per word.
REQ-029 data SHALL hold its last value when wrreq=0.
REQ-030 ovf_err SHALL set on any cycle with wrreq=1 and wrfull=1; cleared by clr_err=1; set wins over simultaneous clear.
REQ-031 Zero-length frames do not exist; s_last only qualifies an accepted byte.

Reset
REQ-032 While aclr=0: state EVEN, hold=0, byte count=0, wrreq=0, data=0, frame_cnt=0, ovf_err=0, s_ready=0.
REQ-033 Reset mid-frame SHALL discard held byte and partial count; no pad or trailer word emitted.
REQ-034 After aclr rises, first accepted byte SHALL start a new frame.

Structure
REQ-035 Package fifo_wr_pkg SHALL hold the FSM state enum, MARGIN and PAD defaults, and trailer width constant (16).
REQ-036 Single module, no sub-modules; FSM, packer, counters and error flag in one file.

Verification
REQ-037 Frame 8'h11,22,33,44 (last on 44), FIFO empty -> writes 16'h1122, 16'h3344, 16'h0004; frame_cnt=1.
REQ-038 Frame 8'hA1,B2,C3 (last on C3) -> writes 16'hA1B2, 16'hC300, 16'h0003; frame_cnt=1.
REQ-039 wrusedw = 2044 (SHENBIT=11, MARGIN=4) during TRAIL -> s_ready=0, no trailer until wrusedw=2043, then 16'h0004-style trailer written.
REQ-040 Force wrfull=1 while a word is written -> ovf_err=1 stays set; clr_err pulse -> 0; clr_err with simultaneous overflow -> remains 1.
REQ-041 aclr low after byte 8'h55 accepted in EVEN -> no write; next frame 8'h66,77(last) -> 16'h6677, 16'h0002.
REQ-042 Back-to-back frames with s_valid held high -> s_ready low exactly one cycle per frame (TRAIL), byte stream lossless, frame_cnt increments per frame.
